// File: rtl/vm_txn_if.sv
// User, supplier and inventory-table signals of the vm2002 transaction controller.
// master drives the pins and the table read data, and slave is the controller.
interface vm_txn_if #(
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 5,
  parameter int COST_W = 8,
  parameter int BAL_W  = 16
);
  logic              coin_valid;
  logic [7:0]        coin_amt;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_item;
  logic              cancel;
  logic              sup_valid;
  logic [IDX_W-1:0]  sup_item;
  logic [3:0]        sup_count;
  logic              sup_ready;
  logic              sup_err;
  logic [IDX_W-1:0]  tbl_rd_item;
  logic [CNT_W-1:0]  tbl_rd_count;
  logic [COST_W-1:0] tbl_rd_cost;
  logic              tbl_wr_en;
  logic [IDX_W-1:0]  tbl_wr_item;
  logic [CNT_W-1:0]  tbl_wr_count;
  logic              dispense_valid;
  logic [IDX_W-1:0]  dispense_item;
  logic              change_valid;
  logic [BAL_W-1:0]  change_amt;
  logic              coin_reject;
  logic [BAL_W-1:0]  balance;
  logic [2:0]        status;

  modport master (
    output coin_valid, coin_amt, sel_valid, sel_item, cancel,
           sup_valid, sup_item, sup_count, tbl_rd_count, tbl_rd_cost,
    input  sup_ready, sup_err, tbl_rd_item, tbl_wr_en, tbl_wr_item, tbl_wr_count,
           dispense_valid, dispense_item, change_valid, change_amt,
           coin_reject, balance, status
  );

  modport slave (
    input  coin_valid, coin_amt, sel_valid, sel_item, cancel,
           sup_valid, sup_item, sup_count, tbl_rd_count, tbl_rd_cost,
    output sup_ready, sup_err, tbl_rd_item, tbl_wr_en, tbl_wr_item, tbl_wr_count,
           dispense_valid, dispense_item, change_valid, change_amt,
           coin_reject, balance, status
  );
endinterface

// File: rtl/vm_txn_ctrl.sv
// vm2002 purchase sequencer: credit -> select -> lookup -> dispense -> change.
// It also shares the single inventory-table port between purchase and supplier restock.
module vm_txn_ctrl #(
  parameter int NUM_ITEMS   = 8,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 5,
  parameter int MAX_STOCK   = 16,
  parameter int COST_W      = 8,
  parameter int BAL_W       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic     clk,
  input logic     rst,
  vm_txn_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_DISP   = 3'd3;
  localparam logic [2:0] S_CHANGE = 3'd4;

  localparam logic [2:0] ST_CREDIT  = 3'd1;
  localparam logic [2:0] ST_VENDED  = 3'd2;
  localparam logic [2:0] ST_SOLDOUT = 3'd3;
  localparam logic [2:0] ST_INSUFF  = 3'd4;
  localparam logic [2:0] ST_CANCEL  = 3'd5;
  localparam logic [2:0] ST_TIMEOUT = 3'd6;

  logic [2:0]        state_q, state_d, status_q, status_d;
  logic [BAL_W-1:0]  bal_q, bal_d, chg_amt_q, chg_amt_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              disp_q, disp_d, chg_q, chg_d, rej_q, rej_d, sup_err_q, sup_err_d;
  logic              pwr_en_q, pwr_en_d;
  logic [CNT_W-1:0]  pwr_cnt_q, pwr_cnt_d;

  logic [BAL_W:0]    bal_sum;
  logic [BAL_W-1:0]  rem;
  logic [CNT_W:0]    sup_sum;
  logic              sup_hs, sup_fit;

  assign bal_sum = {1'b0, bal_q} + (BAL_W+1)'(bus.coin_amt);
  assign rem     = bal_q - BAL_W'(cost_q);

  // Purchase owns the table from lookup until its count write has been issued.
  assign bus.sup_ready   = (state_q != S_LOOKUP) && (state_q != S_DISP);
  assign bus.tbl_rd_item = bus.sup_ready ? bus.sup_item : sel_q;
  assign sup_hs          = bus.sup_valid && bus.sup_ready;
  assign sup_sum         = {1'b0, bus.tbl_rd_count} + (CNT_W+1)'(bus.sup_count);
  assign sup_fit         = sup_sum <= (CNT_W+1)'(MAX_STOCK);
  assign sup_err_d       = sup_hs && !sup_fit;

  assign bus.tbl_wr_en    = pwr_en_q || (sup_hs && sup_fit);
  assign bus.tbl_wr_item  = pwr_en_q ? sel_q : bus.sup_item;
  assign bus.tbl_wr_count = pwr_en_q ? pwr_cnt_q : sup_sum[CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    bal_d     = bal_q;
    sel_d     = sel_q;
    cost_d    = cost_q;
    tmr_d     = tmr_q;
    chg_amt_d = chg_amt_q;
    pwr_cnt_d = pwr_cnt_q;
    disp_d    = 1'b0;
    chg_d     = 1'b0;
    rej_d     = 1'b0;
    pwr_en_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.coin_valid) begin
          bal_d    = BAL_W'(bus.coin_amt);
          tmr_d    = '0;
          state_d  = S_CREDIT;
          status_d = ST_CREDIT;
        end
      end
      S_CREDIT: begin
        if (bus.cancel) begin
          rej_d     = bus.coin_valid;
          chg_d     = 1'b1;
          chg_amt_d = bal_q;
          state_d   = S_CHANGE;
          status_d  = ST_CANCEL;
        end else begin
          if (bus.coin_valid) begin
            if (bal_sum[BAL_W]) rej_d = 1'b1;
            else                bal_d = bal_sum[BAL_W-1:0];
          end
          if (bus.coin_valid || bus.sel_valid) tmr_d = '0;
          if (bus.sel_valid) begin
            sel_d   = bus.sel_item;
            state_d = S_LOOKUP;
          end else if (!bus.coin_valid) begin
            if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
              chg_d     = 1'b1;
              chg_amt_d = bal_q;
              state_d   = S_CHANGE;
              status_d  = ST_TIMEOUT;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
        end
      end
      S_LOOKUP: begin
        rej_d = bus.coin_valid;
        tmr_d = '0;
        if (bus.tbl_rd_count == '0) begin
          state_d  = S_CREDIT;
          status_d = ST_SOLDOUT;
        end else if (bal_q < BAL_W'(bus.tbl_rd_cost)) begin
          state_d  = S_CREDIT;
          status_d = ST_INSUFF;
        end else begin
          cost_d    = bus.tbl_rd_cost;
          disp_d    = 1'b1;
          pwr_en_d  = 1'b1;
          pwr_cnt_d = bus.tbl_rd_count - 1'b1;
          state_d   = S_DISP;
          status_d  = ST_VENDED;
        end
      end
      S_DISP: begin
        rej_d = bus.coin_valid;
        bal_d = rem;
        if (rem != '0) begin
          chg_d     = 1'b1;
          chg_amt_d = rem;
          state_d   = S_CHANGE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        rej_d   = bus.coin_valid;
        bal_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      status_q  <= '0;
      bal_q     <= '0;
      sel_q     <= '0;
      cost_q    <= '0;
      tmr_q     <= '0;
      chg_amt_q <= '0;
      pwr_cnt_q <= '0;
      disp_q    <= 1'b0;
      chg_q     <= 1'b0;
      rej_q     <= 1'b0;
      pwr_en_q  <= 1'b0;
      sup_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      bal_q     <= bal_d;
      sel_q     <= sel_d;
      cost_q    <= cost_d;
      tmr_q     <= tmr_d;
      chg_amt_q <= chg_amt_d;
      pwr_cnt_q <= pwr_cnt_d;
      disp_q    <= disp_d;
      chg_q     <= chg_d;
      rej_q     <= rej_d;
      pwr_en_q  <= pwr_en_d;
      sup_err_q <= sup_err_d;
    end
  end

  assign bus.dispense_valid = disp_q;
  assign bus.dispense_item  = sel_q;
  assign bus.change_valid   = chg_q;
  assign bus.change_amt     = chg_amt_q;
  assign bus.coin_reject    = rej_q;
  assign bus.balance        = bal_q;
  assign bus.status         = status_q;
  assign bus.sup_err        = sup_err_q;
endmodule

// File: tb/tb_vm_txn_ctrl.sv
// Directed bench for vm_txn_ctrl with a behavioural inventory table.
module tb_vm_txn_ctrl;
  localparam int TIMEOUT_CYC = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  int   n;

  vm_txn_if #(.IDX_W(3), .CNT_W(5), .COST_W(8), .BAL_W(16)) bus ();

  vm_txn_ctrl #(
    .NUM_ITEMS(8), .IDX_W(3), .CNT_W(5), .MAX_STOCK(16),
    .COST_W(8), .BAL_W(16), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [4:0] cnt_m  [8];
  logic [7:0] cost_m [8];
  localparam logic [4:0] CNT_INIT  [8] = '{5'd5, 5'd4, 5'd3, 5'd10, 5'd0, 5'd0, 5'd7, 5'd8};
  localparam logic [7:0] COST_INIT [8] = '{8'd10, 8'd60, 8'd75, 8'd40, 8'd30, 8'd50, 8'd20, 8'd90};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_m[i]  <= CNT_INIT[i];
        cost_m[i] <= COST_INIT[i];
      end
    end else if (bus.tbl_wr_en) begin
      cnt_m[bus.tbl_wr_item] <= bus.tbl_wr_count;
    end
  end
  assign bus.tbl_rd_count = cnt_m[bus.tbl_rd_item];
  assign bus.tbl_rd_cost  = cost_m[bus.tbl_rd_item];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [7:0] amt);
    bus.coin_valid = 1'b1;
    bus.coin_amt   = amt;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [2:0] item);
    bus.sel_valid = 1'b1;
    bus.sel_item  = item;
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  initial begin
    bus.coin_valid = 0; bus.coin_amt = 0; bus.sel_valid = 0; bus.sel_item = 0;
    bus.cancel = 0; bus.sup_valid = 0; bus.sup_item = 0; bus.sup_count = 0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_status", 32'(bus.status), 0);
    chk("rst_bal", 32'(bus.balance), 0);
    chk("rst_sup_ready", 32'(bus.sup_ready), 1);
    chk("rst_pulses", {bus.dispense_valid, bus.change_valid, bus.coin_reject, bus.sup_err, bus.tbl_wr_en}, 0);

    // normal purchase with change
    coin(25);
    chk("c1_bal", 32'(bus.balance), 25);
    chk("c1_status", 32'(bus.status), 1);
    coin(25); coin(50);
    chk("c3_bal", 32'(bus.balance), 100);
    sel(2);
    chk("lk_sup_ready", 32'(bus.sup_ready), 0);
    chk("lk_rd_item", 32'(bus.tbl_rd_item), 2);
    chk("lk_disp", 32'(bus.dispense_valid), 0);
    tick();
    chk("dp_valid", 32'(bus.dispense_valid), 1);
    chk("dp_item", 32'(bus.dispense_item), 2);
    chk("dp_wr", {bus.tbl_wr_en, 3'(bus.tbl_wr_item), 5'(bus.tbl_wr_count)}, {1'b1, 3'd2, 5'd2});
    chk("dp_status", 32'(bus.status), 2);
    tick();
    chk("ch_valid", 32'(bus.change_valid), 1);
    chk("ch_amt", 32'(bus.change_amt), 25);
    chk("ch_disp_off", 32'(bus.dispense_valid), 0);
    chk("tbl_item2", 32'(cnt_m[2]), 2);
    tick();
    chk("idle_chg_off", 32'(bus.change_valid), 0);
    chk("idle_bal", 32'(bus.balance), 0);

    // sold out
    coin(100);
    sel(5);
    chk("so_wr", 32'(bus.tbl_wr_en), 0);
    tick();
    chk("so_status", 32'(bus.status), 3);
    chk("so_bal", 32'(bus.balance), 100);
    chk("so_disp", {bus.dispense_valid, bus.tbl_wr_en}, 0);
    do_cancel();
    chk("so_cancel_chg", {bus.change_valid, 16'(bus.change_amt)}, {1'b1, 16'd100});
    chk("so_cancel_status", 32'(bus.status), 5);
    tick();

    // insufficient, then top-up with coin+select in the same cycle
    coin(50);
    sel(1);
    tick();
    chk("in_status", 32'(bus.status), 4);
    chk("in_bal", 32'(bus.balance), 50);
    bus.coin_valid = 1'b1; bus.coin_amt = 10;
    sel(1);
    bus.coin_valid = 1'b0;
    chk("in_lk_bal", 32'(bus.balance), 60);
    tick();
    chk("in_dp", {bus.dispense_valid, 3'(bus.dispense_item), 5'(bus.tbl_wr_count)}, {1'b1, 3'd1, 5'd3});
    tick();
    chk("in_no_chg", 32'(bus.change_valid), 0);
    chk("in_bal0", 32'(bus.balance), 0);
    chk("in_status2", 32'(bus.status), 2);

    // balance overflow
    coin(240);
    repeat (256) coin(255);
    chk("ov_bal", 32'(bus.balance), 32'hFFF0);
    coin(8'h20);
    chk("ov_rej", 32'(bus.coin_reject), 1);
    chk("ov_bal_kept", 32'(bus.balance), 32'hFFF0);
    tick();
    chk("ov_rej_off", 32'(bus.coin_reject), 0);
    do_cancel();
    chk("ov_chg", {bus.change_valid, 16'(bus.change_amt)}, {1'b1, 16'hFFF0});
    chk("ov_status", 32'(bus.status), 5);
    tick();

    // restock: fits exactly, then overflow
    bus.sup_valid = 1'b1; bus.sup_item = 3; bus.sup_count = 6;
    #1;
    chk("rs_wr", {bus.sup_ready, bus.tbl_wr_en, 3'(bus.tbl_wr_item), 5'(bus.tbl_wr_count)},
        {1'b1, 1'b1, 3'd3, 5'd16});
    tick();
    chk("rs_err0", 32'(bus.sup_err), 0);
    chk("rs_tbl3", 32'(cnt_m[3]), 16);
    bus.sup_count = 1;
    #1;
    chk("rs_ovf_nowr", 32'(bus.tbl_wr_en), 0);
    tick();
    bus.sup_valid = 1'b0;
    chk("rs_err1", 32'(bus.sup_err), 1);
    chk("rs_tbl3_kept", 32'(cnt_m[3]), 16);
    tick();
    chk("rs_err_off", 32'(bus.sup_err), 0);

    // restock stalled while purchase owns the table
    coin(100);
    sel(2);
    bus.sup_valid = 1'b1; bus.sup_item = 4; bus.sup_count = 1;
    #1;
    chk("st_lk_ready", {bus.sup_ready, bus.tbl_wr_en}, 0);
    tick();
    chk("st_dp_ready", 32'(bus.sup_ready), 0);
    chk("st_dp_wr", {bus.tbl_wr_en, 3'(bus.tbl_wr_item), 5'(bus.tbl_wr_count)}, {1'b1, 3'd2, 5'd1});
    tick();
    chk("st_ch_wr", {bus.sup_ready, bus.tbl_wr_en, 3'(bus.tbl_wr_item), 5'(bus.tbl_wr_count)},
        {1'b1, 1'b1, 3'd4, 5'd1});
    tick();
    bus.sup_valid = 1'b0;
    chk("st_tbl4", 32'(cnt_m[4]), 1);

    // timeout refund
    coin(5);
    n = 0;
    while (!bus.change_valid && n < TIMEOUT_CYC + 100) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), TIMEOUT_CYC);
    chk("to_chg", {bus.change_valid, 16'(bus.change_amt)}, {1'b1, 16'd5});
    chk("to_status", 32'(bus.status), 6);
    tick();

    // reset in DISPENSE
    coin(100);
    sel(2);
    tick();
    chk("rd_disp", 32'(bus.dispense_valid), 1);
    rst = 1'b1;
    tick();
    chk("rd_pulses", {bus.dispense_valid, bus.change_valid, bus.tbl_wr_en}, 0);
    chk("rd_bal", 32'(bus.balance), 0);
    chk("rd_status", 32'(bus.status), 0);
    rst = 1'b0;
    tick();
    chk("rd_no_chg", {bus.change_valid, 16'(bus.balance)}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
